// File: rtl/pacman_pkg.sv
// Shared Pacman definitions: direction encoding and the press priority encoder.
// The movement FSM decodes cmd_dir with the same dir_t encoding.
package pacman_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  // Fixed priority up > down > left > right. The result is only meaningful
  // when at least one press is high.
  function automatic dir_t prio_dir(input logic up, input logic down,
                                    input logic left, input logic right);
    dir_t d;
    d = DIR_UP;
    if (up)         d = DIR_UP;
    else if (down)  d = DIR_DOWN;
    else if (left)  d = DIR_LEFT;
    else if (right) d = DIR_RIGHT;
    return d;
  endfunction

endpackage

// File: rtl/dir_cmd_queue_if.sv
// Direction command handshake between the queue and the movement FSM.
//   valid : head entry available (producer -> consumer)
//   dir   : head direction       (producer -> consumer)
//   ready : consumer takes head  (consumer -> producer)
interface dir_cmd_if;
  import pacman_pkg::*;

  logic valid;
  dir_t dir;
  logic ready;

  modport master (output valid, output dir, input ready);
  modport slave  (input valid, input dir, output ready);
endinterface

// File: rtl/dir_cmd_queue_prio_enc.sv
// dir_prio_enc: folds four single-cycle press pulses into one push strobe and
// a direction. Lower-priority simultaneous presses are simply discarded.
//   press_*  : debounced press pulses
//   push     : any press high this cycle
//   dir      : winning direction
module dir_prio_enc
  import pacman_pkg::*;
(
  input  logic press_up,
  input  logic press_down,
  input  logic press_left,
  input  logic press_right,
  output logic push,
  output dir_t dir
);

  assign push = press_up | press_down | press_left | press_right;
  assign dir  = prio_dir(press_up, press_down, press_left, press_right);

endmodule

// File: rtl/dir_cmd_queue.sv
// dir_cmd_queue: circular FIFO of direction commands fed by button presses and
// drained by the movement FSM over a valid/ready handshake.
//   clk, rst_n   : clock, async active-low reset
//   press_*      : one-cycle press pulses (one push per cycle after priority)
//   cmd          : master side of dir_cmd_if (valid/dir out, ready in)
//   count        : entries held, 0..DEPTH
//   ovf, ovf_clr : sticky drop-on-full flag and its clear (set wins)
// Build option: define DIR_QUEUE_DEDUP_EN to drop a push whose direction
// matches the newest stored entry while the queue is non-empty.
module dir_cmd_queue
  import pacman_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          press_up,
  input  logic          press_down,
  input  logic          press_left,
  input  logic          press_right,
  dir_cmd_if.master     cmd,
  output logic [CW-1:0] count,
  output logic          ovf,
  input  logic          ovf_clr
);

  localparam int AW = $clog2(DEPTH);

  logic          push;
  dir_t          push_dir;
  dir_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          valid_q, ovf_q;
  logic          pop, full, dup, push_ok, drop_full;

  dir_prio_enc u_enc (
    .press_up    (press_up),
    .press_down  (press_down),
    .press_left  (press_left),
    .press_right (press_right),
    .push        (push),
    .dir         (push_dir)
  );

  assign pop  = valid_q && cmd.ready;
  assign full = (cnt == CW'(DEPTH));

`ifdef DIR_QUEUE_DEDUP_EN
  // Newest entry sits just behind wr_ptr; it still counts even if it is the
  // head being popped this cycle.
  assign dup = (cnt != '0) && (push_dir == mem[wr_ptr - AW'(1)]);
`else
  assign dup = 1'b0;
`endif

  // A pop in the same cycle frees the slot the push needs.
  assign push_ok   = push && !dup && (!full || pop);
  assign drop_full = push && !dup && full && !pop;

  always_comb begin
    cnt_nxt = cnt;
    if (push_ok && !pop)      cnt_nxt = cnt + CW'(1);
    else if (!push_ok && pop) cnt_nxt = cnt - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      // Cleared so cmd_dir reads 00 out of reset.
      for (int i = 0; i < DEPTH; i++) mem[i] <= DIR_UP;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_dir;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      cnt     <= cnt_nxt;
      valid_q <= (cnt_nxt != '0);
      if (drop_full)    ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
    end
  end

  assign cmd.valid = valid_q;
  assign cmd.dir   = mem[rd_ptr];
  assign count     = cnt;
  assign ovf       = ovf_q;

endmodule
